// File: rtl/rf_write_arbiter_if.sv
// Writeback bus between two result sources, the register-file write port and the forwarding tap.
// The arbiter takes the slave view; the producers and the register file take the master view.
interface rf_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic              stall;
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    modport slave (
        input  stall, a_valid, a_addr, a_data, b_valid, b_addr, b_data, rd_addr,
        output a_ready, b_ready, wr_en, wr_addr, wr_data, fwd_hit, fwd_data
    );

    modport master (
        output stall, a_valid, a_addr, a_data, b_valid, b_addr, b_data, rd_addr,
        input  a_ready, b_ready, wr_en, wr_addr, wr_data, fwd_hit, fwd_data
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter of two writeback sources onto one register-file write port; accept in N -> write in N+1.
// Backpressure: stall or reset drops both readies; the loser of a contention waits at most one cycle.
module rf_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    rf_write_arbiter_if.slave   bus
);

    logic              last_grant_q, last_grant_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              a_ready, b_ready;
    logic              accept_a, accept_b;

    // last_grant_q==1 means B won last, so A takes the next contention.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (rst_n && !bus.stall) begin
            if (bus.a_valid && (!bus.b_valid || last_grant_q)) begin
                a_ready = 1'b1;
            end else if (bus.b_valid) begin
                b_ready = 1'b1;
            end
        end
    end

    assign accept_a = bus.a_valid & a_ready;
    assign accept_b = bus.b_valid & b_ready;

    always_comb begin
        last_grant_d = last_grant_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        if (accept_a) begin
            last_grant_d = 1'b0;
            wr_en_d      = |bus.a_addr;
            wr_addr_d    = bus.a_addr;
            wr_data_d    = bus.a_data;
        end else if (accept_b) begin
            last_grant_d = 1'b1;
            wr_en_d      = |bus.b_addr;
            wr_addr_d    = bus.b_addr;
            wr_data_d    = bus.b_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign bus.a_ready  = a_ready;
    assign bus.b_ready  = b_ready;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.fwd_hit  = wr_en_q && (bus.rd_addr == wr_addr_q) && (bus.rd_addr != '0);
    assign bus.fwd_data = wr_data_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: inputs change 1ns after the rising edge, outputs are checked there too.
module tb_rf_write_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    rf_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    rf_write_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.stall = 1'b0; bus.rd_addr = 5'd0;
        bus.a_valid = 1'b1; bus.a_addr = 5'd9;  bus.a_data = 32'h1111_1111;
        bus.b_valid = 1'b1; bus.b_addr = 5'd10; bus.b_data = 32'h2222_2222;
        #1 rst_n = 1'b0;
        #2;
        n_checks++; if (bus.a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready: got %b want 0", bus.a_ready); end
        n_checks++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready: got %b want 0", bus.b_ready); end
        n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
        n_checks++; if (bus.wr_addr !== 5'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d want 0", bus.wr_addr); end
        n_checks++; if (bus.wr_data !== 32'd0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", bus.wr_data); end
        n_checks++; if (bus.fwd_hit !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_hit: got %b want 0", bus.fwd_hit); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        n_checks++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL release_a_ready: got %b want 1", bus.a_ready); end
        n_checks++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL release_b_ready: got %b want 0", bus.b_ready); end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        edge_step();
        n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL release_idle_wr_en: got %b want 0", bus.wr_en); end
    endtask

    task automatic test_single();
        bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL single_a_ready: got %b want 1", bus.a_ready); end
        edge_step();
        bus.a_valid = 1'b0;
        n_checks++; if (bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL single_wr_en: got %b want 1", bus.wr_en); end
        n_checks++; if (bus.wr_addr !== 5'd5) begin n_fail++; $display("FAIL single_wr_addr: got %0d want 5", bus.wr_addr); end
        n_checks++; if (bus.wr_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_wr_data: got %h want deadbeef", bus.wr_data); end
        edge_step();
        n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL single_idle_wr_en: got %b want 0", bus.wr_en); end
        n_checks++; if (bus.wr_addr !== 5'd5) begin n_fail++; $display("FAIL single_hold_addr: got %0d want 5", bus.wr_addr); end
        n_checks++; if (bus.wr_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_hold_data: got %h want deadbeef", bus.wr_data); end
    endtask

    task automatic test_zero_reg();
        bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 32'h0000_1234; bus.rd_addr = 5'd0;
        #1;
        n_checks++; if (bus.b_ready !== 1'b1) begin n_fail++; $display("FAIL zero_b_ready: got %b want 1", bus.b_ready); end
        n_checks++; if (bus.a_ready !== 1'b0) begin n_fail++; $display("FAIL zero_a_ready: got %b want 0", bus.a_ready); end
        edge_step();
        bus.b_valid = 1'b0;
        n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL zero_wr_en: got %b want 0", bus.wr_en); end
        n_checks++; if (bus.fwd_hit !== 1'b0) begin n_fail++; $display("FAIL zero_fwd_hit: got %b want 0", bus.fwd_hit); end
        n_checks++; if (bus.wr_addr !== 5'd0) begin n_fail++; $display("FAIL zero_wr_addr: got %0d want 0", bus.wr_addr); end
        n_checks++; if (bus.wr_data !== 32'h0000_1234) begin n_fail++; $display("FAIL zero_wr_data: got %h want 00001234", bus.wr_data); end
    endtask

    // B won the zero-register write, so A must lead the alternation.
    task automatic test_contention();
        logic [4:0] exp_addr [4];
        logic       exp_a;
        exp_addr = '{5'd1, 5'd11, 5'd2, 5'd12};
        bus.a_valid = 1'b1; bus.a_addr = 5'd1;  bus.a_data = 32'hA000_0001;
        bus.b_valid = 1'b1; bus.b_addr = 5'd11; bus.b_data = 32'hB000_000B;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0);
            n_checks++; if (bus.a_ready !== exp_a) begin n_fail++; $display("FAIL cont_a_ready[%0d]: got %b want %b", i, bus.a_ready, exp_a); end
            n_checks++; if (bus.b_ready !== !exp_a) begin n_fail++; $display("FAIL cont_b_ready[%0d]: got %b want %b", i, bus.b_ready, !exp_a); end
            edge_step();
            n_checks++; if (bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL cont_wr_en[%0d]: got %b want 1", i, bus.wr_en); end
            n_checks++; if (bus.wr_addr !== exp_addr[i]) begin n_fail++; $display("FAIL cont_wr_addr[%0d]: got %0d want %0d", i, bus.wr_addr, exp_addr[i]); end
            n_checks++;
            if (bus.wr_data !== ((exp_a ? 32'hA000_0000 : 32'hB000_0000) | {27'd0, exp_addr[i]})) begin
                n_fail++; $display("FAIL cont_wr_data[%0d]: got %h for addr %0d", i, bus.wr_data, exp_addr[i]);
            end
            if (exp_a) begin
                bus.a_addr = bus.a_addr + 5'd1; bus.a_data = 32'hA000_0000 | {27'd0, bus.a_addr};
            end else begin
                bus.b_addr = bus.b_addr + 5'd1; bus.b_data = 32'hB000_0000 | {27'd0, bus.b_addr};
            end
            #1;
        end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        edge_step();
        n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL cont_idle_wr_en: got %b want 0", bus.wr_en); end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        bus.a_valid = 1'b1; bus.a_addr = 5'd3;  bus.a_data = 32'h0000_0333;
        bus.b_valid = 1'b1; bus.b_addr = 5'd13; bus.b_data = 32'h0000_1313;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if ({bus.a_ready, bus.b_ready} !== 2'b00) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b want 00", i, {bus.a_ready, bus.b_ready}); end
            edge_step();
            n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL stall_wr_en[%0d]: got %b want 0", i, bus.wr_en); end
        end
        bus.stall = 1'b0;
        #1;
        n_checks++; if ({bus.a_ready, bus.b_ready} !== 2'b10) begin n_fail++; $display("FAIL stall_release_ready: got %b want 10", {bus.a_ready, bus.b_ready}); end
        edge_step();
        // The write just registered must still appear while the next cycle is stalled.
        bus.a_valid = 1'b0; bus.stall = 1'b1;
        #1;
        n_checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd3) begin n_fail++; $display("FAIL stall_present: got en=%b addr=%0d want en=1 addr=3", bus.wr_en, bus.wr_addr); end
        n_checks++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL stall_b_ready: got %b want 0", bus.b_ready); end
        edge_step();
        bus.stall = 1'b0; bus.b_valid = 1'b0;
        n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL stall_after_wr_en: got %b want 0", bus.wr_en); end
    endtask

    task automatic test_forward_reset();
        bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 32'hA5A5_A5A5; bus.rd_addr = 5'd7;
        edge_step();
        bus.a_valid = 1'b0;
        n_checks++; if (bus.fwd_hit !== 1'b1) begin n_fail++; $display("FAIL fwd_hit: got %b want 1", bus.fwd_hit); end
        n_checks++; if (bus.fwd_data !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL fwd_data: got %h want a5a5a5a5", bus.fwd_data); end
        bus.rd_addr = 5'd8;
        #1;
        n_checks++; if (bus.fwd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_miss: got %b want 0", bus.fwd_hit); end
        bus.rd_addr = 5'd7;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL async_wr_en: got %b want 0", bus.wr_en); end
        n_checks++; if (bus.fwd_hit !== 1'b0) begin n_fail++; $display("FAIL async_fwd_hit: got %b want 0", bus.fwd_hit); end
        n_checks++; if (bus.wr_addr !== 5'd0) begin n_fail++; $display("FAIL async_wr_addr: got %0d want 0", bus.wr_addr); end
        edge_step();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_zero_reg();
        test_contention();
        test_stall();
        test_forward_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Arbitrates two writeback sources (ALU result path A, load/multi-cycle unit path B) onto the single write port of the 32×32-bit register file. Valid/ready handshake on each source, round-robin under contention, and a one-cycle registered write port. Drops writes to register 0 and provides a forwarding tap for the write in flight. Sits between the execute/memory stages and the register file built from the pos-edge 32-bit registers.

## Interface
- DATA_W, 32, width of write data
- ADDR_W, 5, width of register address
- clk  in  1  pos-edge clock for all state
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  register file busy; blocks all accepts while 1
- a_valid  in  1  source A has a write pending
- a_ready  out  1  source A write accepted this cycle when a_valid&a_ready
- a_addr  in  ADDR_W  source A destination register
- a_data  in  DATA_W  source A write data
- b_valid / b_ready / b_addr / b_data  same as A for source B
- wr_en  out  1  register file write enable (registered)
- wr_addr  out  ADDR_W  register file write address (registered)
- wr_data  out  DATA_W  register file write data (registered)
- rd_addr  in  ADDR_W  read address to check against write in flight
- fwd_hit  out  1  rd_addr matches write in flight
- fwd_data  out  DATA_W  equals wr_data

## Operation
- State: last_grant (1 bit, 0=A, 1=B), wr_en/wr_addr/wr_data registers.
- Grant (combinational):
  - rst_n=0 or stall=1: a_ready=b_ready=0.
  - Only one valid: that source gets ready=1.
  - Both valid: the source not equal to last_grant gets ready=1; the other gets 0.
  - Neither valid: both ready=0.
  - a_ready and b_ready are never both 1.
- Accept = valid&ready. At most one accept per cycle.
- On accept: last_grant ← accepted source; wr_addr ← addr; wr_data ← data; wr_en ← (addr≠0).
- No accept: wr_en ← 0; wr_addr and wr_data hold.
- Address 0: accepted normally (ready, pointer update) but never produces wr_en=1.
- Source rule: once valid is asserted, addr/data stay stable and valid stays high until accepted. The arbiter does not check this rule.
- fwd_hit = wr_en & (rd_addr==wr_addr) & (rd_addr≠0). fwd_data = wr_data.

## Timing
- Reset (async, immediate): wr_en=0, wr_addr=0, wr_data=0, last_grant=1, so A wins the first contention. fwd_hit=0. Ready outputs are 0 while rst_n=0.
- Latency: accept in cycle N gives wr_en/wr_addr/wr_data valid in cycle N+1. The register file captures them at the end of N+1.
- Throughput: one write per cycle. Under continuous contention, grants alternate A,B,A,B. Worst-case wait is 1 cycle.
- stall: asserting stall in cycle N blocks accepts in N only. wr_en in N+1 is 0. The pointer is unchanged. The write already registered in N is still presented in N.
- Reset mid-operation: a pending registered write is discarded (wr_en drops asynchronously). An accept in the cycle rst_n falls is lost. Sources must re-present after reset.
- Deassertion of rst_n: the first accept is possible in the first rising edge with rst_n=1.

## Test plan
- Reset: rst_n=0 with a_valid=b_valid=1 → a_ready=b_ready=0, wr_en=0, wr_addr=0, wr_data=0. Release → first cycle a_ready=1, b_ready=0.
- Single source: a_valid=1, a_addr=5, a_data=0xDEADBEEF for one cycle → next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF. Following cycle wr_en=0, addr/data hold.
- Contention: both valid continuously for 4 cycles (A addr 1..4, B addr 11..14, each source advancing its addr on its own accept) → writes in order 1,11,2,12, each one cycle apart.
- Zero register: b_valid=1, b_addr=0, b_data=0x1234 → b_ready=1, next cycle wr_en=0, fwd_hit=0. Last_grant=B, so the next contention goes to A.
- Stall: both valid, stall=1 for 2 cycles → ready=0 and wr_en=0 throughout. The pointer is unchanged and A is granted on release.
- Forwarding/async reset: write addr 7 data 0xA5A5A5A5 with rd_addr=7 → fwd_hit=1, fwd_data=0xA5A5A5A5. Then pull rst_n low mid-cycle → wr_en and fwd_hit go 0 before the next clk edge.
